hex_scroll_controller: RTL and testbench



---
 rtl/hex_scroll_controller.sv | 186 ++++++++++++++++++
 tb/tb_hex_scroll_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_controller.sv
// hex_scroll_controller
// Buffers a message of active-low 7-segment patterns ({g,f,e,d,c,b,a}) and
// scrolls it right-to-left across HEX5..HEX0, followed by a six-digit blank gap.
// Optional build macro: HEX_SCROLL_REVERSE_EN adds a 'dir' input.
// When dir=1, the window position steps backwards instead of forwards.
module hex_scroll_controller #(
  parameter int MSG_LEN     = 16,
  parameter int STEP_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_data,
  input  logic       wr_last,
  input  logic       enable,
  input  logic       clear,
`ifdef HEX_SCROLL_REVERSE_EN
  input  logic       dir,
`endif
  output logic       active,
  output logic       wrap_pulse,
  output logic [6:0] hex5,
  output logic [6:0] hex4,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  // The width must hold pos+5, where pos can reach len+5, so the largest value is MSG_LEN+10.
  localparam int PW = $clog2(MSG_LEN + 12);
  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   len_reg, len_next;
  logic [PW-1:0]   pos_reg, pos_next;
  logic [TW-1:0]   tick_reg, tick_next;
  logic            wrap_reg, wrap_next;
  logic [41:0]     hex_reg, hex_next;
  logic [6:0]      buf_reg  [MSG_LEN];
  logic [6:0]      buf_next [MSG_LEN];
  logic [PW-1:0]   period_cur, period_next;
  logic [41:0]     win_flat;
  logic            accept;
  logic            wr_en;

  assign wr_ready    = (state_reg != SCROLL);
  assign active      = (state_reg == SCROLL);
  assign accept      = wr_valid && wr_ready && !clear;
  // The virtual sequence is the message followed by six blanks.
  assign period_cur  = len_reg + PW'(6);
  assign period_next = len_next + PW'(6);

  // Next-state logic: loading, step timing and window position. Clear overrides everything.
  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    len_next    = len_reg;
    pos_next    = pos_reg;
    tick_next   = tick_reg;
    wrap_next   = 1'b0;
    wr_en       = 1'b0;
    if (clear) begin
      state_next  = IDLE;
      wr_ptr_next = '0;
      len_next    = '0;
      pos_next    = '0;
      tick_next   = '0;
    end else begin
      unique case (state_reg)
        IDLE, LOAD: begin
          if (accept) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + PW'(1);
            // A full buffer ends the message even without wr_last.
            if (wr_last || wr_ptr_reg == PW'(MSG_LEN - 1)) begin
              state_next = SCROLL;
              len_next   = wr_ptr_reg + PW'(1);
              pos_next   = '0;
              tick_next  = '0;
            end else begin
              state_next = LOAD;
            end
          end
        end
        SCROLL: begin
          if (enable) begin
            if (tick_reg == TW'(STEP_CYCLES - 1)) begin
              tick_next = '0;
`ifdef HEX_SCROLL_REVERSE_EN
              if (dir) begin
                if (pos_reg == '0) begin
                  pos_next  = period_cur - PW'(1);
                  wrap_next = 1'b1;
                end else begin
                  pos_next  = pos_reg - PW'(1);
                end
              end else
`endif
              if (pos_reg == period_cur - PW'(1)) begin
                pos_next  = '0;
                wrap_next = 1'b1;
              end else begin
                pos_next  = pos_reg + PW'(1);
              end
            end else begin
              tick_next = tick_reg + TW'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Buffer contents after this cycle's write.
  // Forwarding the write lets the first window include the final beat.
  always_comb begin
    for (int i = 0; i < MSG_LEN; i++) begin
      buf_next[i] = buf_reg[i];
      if (wr_en && wr_ptr_reg == PW'(i)) buf_next[i] = wr_data;
    end
  end

  // One window digit per generate slot. Slot gi shows virt((pos+gi) mod P).
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_win
      logic [PW-1:0] idx_raw;
      logic [PW-1:0] idx;
      logic [6:0]    seg;
      // Select the buffered character, or blank when the index lands in the gap.
      always_comb begin
        idx_raw = pos_next + PW'(gi);
        idx     = (idx_raw >= period_next) ? idx_raw - period_next : idx_raw;
        seg     = BLANK;
        for (int i = 0; i < MSG_LEN; i++) begin
          if (idx == PW'(i) && idx < len_next) seg = buf_next[i];
        end
      end
      assign win_flat[(5-gi)*7 +: 7] = seg;
    end
  endgenerate

  assign hex_next = (state_next == SCROLL) ? win_flat : {6{BLANK}};

  // Control and display registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      len_reg    <= '0;
      pos_reg    <= '0;
      tick_reg   <= '0;
      wrap_reg   <= 1'b0;
      hex_reg    <= {6{BLANK}};
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      len_reg    <= len_next;
      pos_reg    <= pos_next;
      tick_reg   <= tick_next;
      wrap_reg   <= wrap_next;
      hex_reg    <= hex_next;
    end
  end

  // Message storage. Entries at or beyond len are never displayed, so there is no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MSG_LEN; i++) buf_reg[i] <= buf_next[i];
  end

  assign wrap_pulse = wrap_reg;
  assign hex5 = hex_reg[41:35];
  assign hex4 = hex_reg[34:28];
  assign hex3 = hex_reg[27:21];
  assign hex2 = hex_reg[20:14];
  assign hex1 = hex_reg[13:7];
  assign hex0 = hex_reg[6:0];

endmodule

// File: tb/tb_hex_scroll_controller.sv
// Bench for hex_scroll_controller (MSG_LEN=8, STEP_CYCLES=4).
// It runs a vector table, hand-written multi-cycle sequences, and random stimulus.
// The random stimulus is checked against a count-based reference model.
module tb_hex_scroll_controller;
  localparam int ML = 8;
  localparam int SC = 4;
  localparam logic [6:0] BL = 7'h7F;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [6:0] wr_data = '0;
  logic       wr_last = 1'b0;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic       active, wrap_pulse;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
`ifdef HEX_SCROLL_REVERSE_EN
  logic       dir = 1'b0;
`endif

  hex_scroll_controller #(.MSG_LEN(ML), .STEP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .enable(enable), .clear(clear),
`ifdef HEX_SCROLL_REVERSE_EN
    .dir(dir),
`endif
    .active(active), .wrap_pulse(wrap_pulse),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  always #5 clk = ~clk;

  logic [41:0] hex_all;
  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        valid;
    logic [6:0]  data;
    logic        last;
    logic        en;
    logic        clr;
    logic        act;
    logic        rdy;
    logic [41:0] hex;
    logic        wrap;
  } vec_t;
  vec_t vecs[20];
  int   n_vec = 0;

  // Reference model state. m_cnt counts the enabled cycles since entering scroll.
  logic [6:0] m_msg[$];
  bit         m_scroll = 1'b0;
  int         m_cnt = 0;
  bit         m_wrap = 1'b0;

  function automatic logic [41:0] hx6(input logic [6:0] a, b, c, d, e, f);
    return {a, b, c, d, e, f};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic v, input logic [6:0] d, input logic l, input logic e,
                         input logic c, input logic a, input logic r, input logic [41:0] h,
                         input logic w);
    vecs[n_vec] = '{v, d, l, e, c, a, r, h, w};
    n_vec++;
  endtask

  task automatic drive(input logic v, input logic [6:0] d, input logic l, input logic e,
                       input logic c);
    wr_valid = v; wr_data = d; wr_last = l; enable = e; clear = c;
  endtask

  // Apply one clock edge, update the model from the inputs present at that edge, then settle.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic void model_reset();
    m_msg.delete();
    m_scroll = 1'b0;
    m_cnt = 0;
    m_wrap = 1'b0;
  endfunction

  function automatic void model_update();
    int p;
    m_wrap = 1'b0;
    if (reset || clear) begin
      model_reset();
    end else if (!m_scroll) begin
      if (wr_valid) begin
        m_msg.push_back(wr_data);
        if (wr_last || m_msg.size() == ML) begin
          m_scroll = 1'b1;
          m_cnt = 0;
        end
      end
    end else if (enable) begin
      p = m_msg.size() + 6;
      m_cnt++;
      if (m_cnt % (SC * p) == 0) m_wrap = 1'b1;
    end
  endfunction

  function automatic logic [41:0] model_hex();
    logic [41:0] r;
    int p, pos, v;
    r = {6{BL}};
    if (m_scroll) begin
      p = m_msg.size() + 6;
      pos = (m_cnt / SC) % p;
      for (int k = 0; k < 6; k++) begin
        v = (pos + k) % p;
        r[(5-k)*7 +: 7] = (v < m_msg.size()) ? m_msg[v] : BL;
      end
    end
    return r;
  endfunction

  initial begin
    logic [41:0] w0, w1, w2, ref_hex;
    int wraps, first_wrap, nxt;
    logic samp_rdy;

    w0 = hx6(7'h08, 7'h47, 7'h11, BL, BL, BL);
    w1 = hx6(7'h47, 7'h11, BL, BL, BL, BL);
    w2 = hx6(7'h11, BL, BL, BL, BL, BL);
    add_vec(1, 7'h08, 0, 1, 0, 0, 1, {6{BL}}, 0);
    add_vec(1, 7'h47, 0, 1, 0, 0, 1, {6{BL}}, 0);
    add_vec(1, 7'h11, 1, 1, 0, 1, 0, w0, 0);
    add_vec(0, 7'h00, 0, 1, 0, 1, 0, w0, 0);
    add_vec(0, 7'h00, 0, 1, 0, 1, 0, w0, 0);
    add_vec(0, 7'h00, 0, 1, 0, 1, 0, w0, 0);
    add_vec(0, 7'h00, 0, 1, 0, 1, 0, w1, 0);
    add_vec(0, 7'h00, 0, 0, 0, 1, 0, w1, 0);
    add_vec(0, 7'h00, 0, 0, 0, 1, 0, w1, 0);
    add_vec(0, 7'h00, 0, 1, 0, 1, 0, w1, 0);
    add_vec(0, 7'h00, 0, 1, 0, 1, 0, w1, 0);
    add_vec(0, 7'h00, 0, 1, 0, 1, 0, w1, 0);
    add_vec(0, 7'h00, 0, 1, 0, 1, 0, w2, 0);
    add_vec(1, 7'h55, 0, 1, 1, 0, 1, {6{BL}}, 0);
    add_vec(1, 7'h22, 1, 1, 0, 1, 0, hx6(7'h22, BL, BL, BL, BL, BL), 0);
    add_vec(0, 7'h00, 0, 1, 1, 0, 1, {6{BL}}, 0);

    // Reset held for three cycles.
    reset = 1'b1;
    repeat (3) step();
    check("reset_hex", hex_all, {6{BL}});
    check("reset_ready", wr_ready, 1);
    check("reset_active", active, 0);
    check("reset_wrap", wrap_pulse, 0);
    reset = 1'b0;

    // Vector table.
    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].en, vecs[i].clr);
      step();
      check($sformatf("vec%0d_out", i), {active, wr_ready, wrap_pulse, hex_all},
            {vecs[i].act, vecs[i].rdy, vecs[i].wrap, vecs[i].hex});
    end

    // Wrap cadence: P=9 and 4 cycles per step give one wrap every 36 cycles.
    drive(1, 7'h08, 0, 1, 0); step();
    drive(1, 7'h47, 0, 1, 0); step();
    drive(1, 7'h11, 1, 1, 0); step();
    drive(0, 7'h00, 0, 1, 0);
    wraps = 0;
    first_wrap = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (wrap_pulse) begin
        wraps++;
        if (first_wrap < 0) first_wrap = c;
      end
      if (c == 35) check("wrap_pre_hex", hex_all, hx6(BL, 7'h08, 7'h47, 7'h11, BL, BL));
      if (c == 36) begin
        check("wrap_hex", hex_all, w0);
        check("wrap_pulse_36", wrap_pulse, 1);
      end
    end
    check("wrap_first", 64'(first_wrap), 64'(36));
    check("wrap_count", 64'(wraps), 64'(1));
    drive(0, 7'h00, 0, 1, 1); step();
    drive(0, 7'h00, 0, 1, 0);

    // Stream 9 beats without wr_last. The buffer fills at 8, so the 9th beat stays pending.
    nxt = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1, 7'(nxt + 1), 0, 1, 0);
      samp_rdy = wr_ready;
      step();
      if (samp_rdy) nxt++;
    end
    check("full_accepted", 64'(nxt), 64'(8));
    check("full_ready", wr_ready, 0);
    check("full_active", active, 1);
    ref_hex = hx6(7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06);
    check("full_hex", hex_all, ref_hex);

    // Freeze in the middle of a step. The tick is at 2, so two more enabled cycles complete the step.
    enable = 1'b0;
    repeat (10) step();
    check("freeze_hex", hex_all, ref_hex);
    enable = 1'b1;
    step();
    check("resume1_hex", hex_all, ref_hex);
    step();
    check("resume2_hex", hex_all, hx6(7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07));

    // Clear during SCROLL while a beat is offered.
    drive(1, 7'h33, 1, 1, 1);
    step();
    check("clear_out", {active, wr_ready, hex_all}, {1'b0, 1'b1, {6{BL}}});
    drive(0, 7'h00, 0, 1, 0);

    // Random stimulus against the reference model.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 999) == 0);
      clear    = ($urandom_range(0, 199) == 0);
      wr_valid = $urandom_range(0, 1) == 1;
      wr_data  = 7'($urandom_range(0, 127));
      wr_last  = ($urandom_range(0, 5) == 0);
      enable   = ($urandom_range(0, 9) != 0);
      step();
      check($sformatf("rand%0d", c), {active, wr_ready, wrap_pulse, hex_all},
            {m_scroll, !m_scroll, m_wrap, model_hex()});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
